y86_fetch_queue: RTL and testbench

Y86_FETCH_QUEUE -- requirements
Module: y86_fetch_queue

---
 rtl/y86_fetch_queue.sv | 198 +++++++++++++++++++
 tb/tb_y86_fetch_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_fetch_queue.sv
// Y86-64 instruction fetch front end: issues fixed-size memory reads into a
// byte queue, decodes the instruction at the queue head and presents it as a
// record with a valid/ready handshake. Halts on halt, an illegal encoding or
// a fetch fault. A redirect restarts fetch at a new PC.
module y86_fetch_queue #(
  parameter int          FETCH_BYTES = 10,
  parameter int          QUEUE_DEPTH = 32,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     mem_req,
  output logic [63:0]              mem_addr,
  input  logic                     mem_valid,
  input  logic [8*FETCH_BYTES-1:0] mem_rdata,
  input  logic                     mem_error,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               icode,
  output logic [3:0]               ifun,
  output logic [3:0]               rA,
  output logic [3:0]               rB,
  output logic [63:0]              valC,
  output logic [63:0]              valP,
  output logic [63:0]              pc_out,
  output logic                     instr_valid,
  output logic                     imem_error,
  output logic                     halted
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] FB_W    = (CW+1)'(FETCH_BYTES);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q;
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail;
  logic [63:0]   fetch_addr_q;
  logic [63:0]   pc_q;
  logic          fault_q;
  logic          inflight_q;
  logic [7:0]    queue_mem [QUEUE_DEPTH];

  // Decode-side signals
  logic [7:0]    win [10];
  logic [3:0]    op_icode, op_ifun;
  logic          need_regids, need_valc, legal;
  logic [3:0]    len;
  logic [3:0]    pop_len;
  logic [63:0]   valc_raw;
  logic          count_ok, err_rec, fire, halt_take;
  logic          append, error_take;
  logic [CW:0]   committed;

  // Queue bookkeeping and control events
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
    tail       = head_q + count_q[AW-1:0];
    committed  = (CW+1)'(count_q) + (inflight_q ? FB_W : '0);
    // Only the response to our own outstanding request counts; redirect wins.
    append     = mem_valid && inflight_q && !mem_error && !redirect_valid && !fault_q;
    error_take = mem_valid && inflight_q && mem_error && !redirect_valid;
    // Space is reserved for the in-flight response, so an append always fits.
    mem_req    = rst_n && (state_q == ST_RUN) && !fault_q && !redirect_valid &&
                 !(mem_valid && mem_error) && ((committed + FB_W) <= DEPTH_W);
    mem_addr   = fetch_addr_q;
    count_ok   = count_q >= CW'(len);
    err_rec    = !count_ok;
    out_valid  = (state_q == ST_RUN) && (count_ok || fault_q);
    fire       = out_valid && out_ready && !redirect_valid;
    halt_take  = fire && (err_rec || !legal || (op_icode == 4'h0));
    pop_len    = (fire && !err_rec) ? len : 4'd0;
  end

  // Peek the first ten queue bytes starting at the head (longest instruction)
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      win[i] = queue_mem[AW'(head_q + AW'(i))];
    end
  end

  // Decode the head instruction: field needs, legality and length
  always_comb begin
    op_icode    = win[0][7:4];
    op_ifun     = win[0][3:0];
    need_regids = 1'b0;
    need_valc   = 1'b0;
    legal       = 1'b0;
    case (op_icode)
      4'h2:       begin need_regids = 1'b1; legal = (op_ifun <= 4'd6); end
      4'h3, 4'h4,
      4'h5:       begin need_regids = 1'b1; need_valc = 1'b1; legal = (op_ifun == 4'd0); end
      4'h6:       begin need_regids = 1'b1; legal = (op_ifun <= 4'd3); end
      4'h7:       begin need_valc = 1'b1; legal = (op_ifun <= 4'd6); end
      4'h8:       begin need_valc = 1'b1; legal = (op_ifun == 4'd0); end
      4'hA, 4'hB: begin need_regids = 1'b1; legal = (op_ifun == 4'd0); end
      4'h0, 4'h1,
      4'h9:       legal = (op_ifun == 4'd0);
      default:    legal = 1'b0;
    endcase
    // An illegal encoding is reported on its opcode byte alone.
    len = legal ? (4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0)) : 4'd1;
    for (int j = 0; j < 8; j++) begin
      valc_raw[8*j +: 8] = need_regids ? win[j+2] : win[j+1];
    end
  end

  // Record outputs; idle values whenever no record is presented
  always_comb begin
    icode       = 4'h0;
    ifun        = 4'h0;
    rA          = 4'hF;
    rB          = 4'hF;
    valC        = 64'h0;
    valP        = 64'h0;
    instr_valid = 1'b0;
    imem_error  = 1'b0;
    pc_out      = pc_q;
    if (out_valid && !err_rec) begin
      icode       = op_icode;
      ifun        = op_ifun;
      rA          = need_regids ? win[1][7:4] : 4'hF;
      rB          = need_regids ? win[1][3:0] : 4'hF;
      valC        = need_valc ? valc_raw : 64'h0;
      valP        = pc_q + 64'(len);
      instr_valid = legal;
    end else if (out_valid) begin
      imem_error  = 1'b1;
      valP        = pc_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: redirect restarts, an accepted terminal record halts
  always_comb begin
    state_d = state_q;
    if (redirect_valid) state_d = ST_RUN;
    else if (halt_take) state_d = ST_HALT;
  end

  // FSM output
  always_comb begin
    halted = (state_q == ST_HALT);
  end

  // Queue pointers, fetch address, PC and fault tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q      <= '0;
      head_q       <= '0;
      fetch_addr_q <= RESET_PC;
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      inflight_q   <= 1'b0;
    end else if (redirect_valid) begin
      count_q      <= '0;
      fetch_addr_q <= redirect_pc;
      pc_q         <= redirect_pc;
      fault_q      <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      inflight_q <= mem_req;
      if (mem_req) fetch_addr_q <= fetch_addr_q + 64'(FETCH_BYTES);
      if (error_take) fault_q <= 1'b1;
      head_q  <= head_q + AW'(pop_len);
      count_q <= count_q + (append ? CW'(FETCH_BYTES) : '0) - CW'(pop_len);
      if (fire && !err_rec) pc_q <= pc_q + 64'(len);
    end
  end

  // Byte storage written at the tail in address order
  always_ff @(posedge clk) begin
    // NOTE: the byte array has no reset; count_q alone decides which entries are meaningful.
    if (rst_n && append) begin
      for (int k = 0; k < FETCH_BYTES; k++) begin
        queue_mem[AW'(tail + AW'(k))] <= mem_rdata[8*k +: 8];
      end
    end
  end

  // An append must always fit in the free space
  always_ff @(posedge clk) begin
    if (rst_n && append) assert (((CW+1)'(count_q) + FB_W) <= DEPTH_W);
  end

endmodule

// File: tb/tb_y86_fetch_queue.sv
// Directed bench for y86_fetch_queue with a byte-array memory model that
// answers each request one cycle later.
module tb_y86_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_valid;
  logic [79:0] mem_rdata;
  logic        mem_error;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc_out;
  logic        instr_valid, imem_error, halted;

  logic [7:0]  imem [512];
  logic [63:0] err_base;
  int          checks;
  int          errors;

  y86_fetch_queue #(.FETCH_BYTES(10), .QUEUE_DEPTH(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .pc_out(pc_out),
    .instr_valid(instr_valid), .imem_error(imem_error), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request before the edge, answer it just after.
  task automatic tick();
    logic        r;
    logic [63:0] a;
    #2;
    r = mem_req;
    a = mem_addr;
    @(posedge clk);
    #1;
    mem_valid = r;
    mem_error = r && (a >= err_base);
    for (int k = 0; k < 10; k++) mem_rdata[8*k +: 8] = imem[9'(a[8:0] + 9'(k))];
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) imem[i] = 8'h00;
    err_base = '1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    mem_valid = 1'b0; mem_error = 1'b0; mem_rdata = '0;
    tick();
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, " out_valid"}, 64'(out_valid), 64'h1);
  endtask

  task automatic rec(input string tag, input logic [63:0] pc, input logic [3:0] ic,
                     input logic [3:0] fn, input logic [3:0] ra, input logic [3:0] rb,
                     input logic [63:0] vp);
    wait_valid(tag);
    check({tag, " pc_out"}, pc_out, pc);
    check({tag, " icode"}, 64'(icode), 64'(ic));
    check({tag, " ifun"}, 64'(ifun), 64'(fn));
    check({tag, " rA"}, 64'(rA), 64'(ra));
    check({tag, " rB"}, 64'(rB), 64'(rb));
    check({tag, " valP"}, valP, vp);
    check({tag, " instr_valid"}, 64'(instr_valid), 64'h1);
    check({tag, " imem_error"}, 64'(imem_error), 64'h0);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [63:0] b_pc [4];
  logic [3:0]  b_ic [4];
  logic [3:0]  b_ra [4];
  logic [3:0]  b_rb [4];
  logic [63:0] b_vp [4];

  initial begin
    checks = 0;
    errors = 0;

    // ---- A: irmovq decode, back-pressure fill, following records ----
    clear_mem();
    imem[0]  = 8'h30; imem[1]  = 8'hF3; imem[2]  = 8'h64;
    imem[10] = 8'h20; imem[11] = 8'h12;
    imem[12] = 8'h60; imem[13] = 8'h45;
    imem[14] = 8'h10; imem[15] = 8'h00;
    do_reset();
    check("rst out_valid", 64'(out_valid), 64'h0);
    check("rst mem_req", 64'(mem_req), 64'h0);
    check("rst halted", 64'(halted), 64'h0);
    check("rst imem_error", 64'(imem_error), 64'h0);
    check("rst icode", 64'(icode), 64'h0);
    check("rst rA", 64'(rA), 64'hF);
    check("rst rB", 64'(rB), 64'hF);
    check("rst valC", valC, 64'h0);
    check("rst pc_out", pc_out, 64'h0);
    rst_n = 1'b1;
    #1;
    check("first mem_req", 64'(mem_req), 64'h1);
    check("first mem_addr", mem_addr, 64'h0);
    wait_valid("A0");
    check("A0 icode", 64'(icode), 64'h3);
    check("A0 ifun", 64'(ifun), 64'h0);
    check("A0 rA", 64'(rA), 64'hF);
    check("A0 rB", 64'(rB), 64'h3);
    check("A0 valC", valC, 64'h64);
    check("A0 valP", valP, 64'h0A);
    check("A0 instr_valid", 64'(instr_valid), 64'h1);
    check("A0 pc_out", pc_out, 64'h0);
    repeat (5) tick();
    check("A stall out_valid", 64'(out_valid), 64'h1);
    check("A stall icode", 64'(icode), 64'h3);
    check("A stall valC", valC, 64'h64);
    check("A stall valP", valP, 64'h0A);
    check("A full mem_req", 64'(mem_req), 64'h0);
    accept();
    rec("A1", 64'h0A, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0C);
    accept();
    rec("A2", 64'h0C, 4'h6, 4'h0, 4'h4, 4'h5, 64'h0E);
    accept();
    rec("A3", 64'h0E, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0F);
    accept();
    rec("A4", 64'h0F, 4'h0, 4'h0, 4'hF, 4'hF, 64'h10);
    accept();
    check("A halted", 64'(halted), 64'h1);
    check("A halted out_valid", 64'(out_valid), 64'h0);

    // ---- B: stream 10 60 23 90 00 with out_ready held high ----
    clear_mem();
    imem[0] = 8'h10; imem[1] = 8'h60; imem[2] = 8'h23; imem[3] = 8'h90; imem[4] = 8'h00;
    b_pc = '{64'h0, 64'h1, 64'h3, 64'h4};
    b_ic = '{4'h1, 4'h6, 4'h9, 4'h0};
    b_ra = '{4'hF, 4'h2, 4'hF, 4'hF};
    b_rb = '{4'hF, 4'h3, 4'hF, 4'hF};
    b_vp = '{64'h1, 64'h3, 64'h4, 64'h5};
    do_reset();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rec($sformatf("B%0d", i), b_pc[i], b_ic[i], 4'h0, b_ra[i], b_rb[i], b_vp[i]);
      tick();
    end
    check("B halted", 64'(halted), 64'h1);
    check("B out_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("B idle mem_req %0d", i), 64'(mem_req), 64'h0);
    end

    // ---- C: illegal 27 followed by halt ----
    clear_mem();
    imem[0] = 8'h27; imem[1] = 8'h00;
    do_reset();
    rst_n = 1'b1;
    out_ready = 1'b1;
    wait_valid("C");
    check("C icode", 64'(icode), 64'h2);
    check("C ifun", 64'(ifun), 64'h7);
    check("C instr_valid", 64'(instr_valid), 64'h0);
    check("C imem_error", 64'(imem_error), 64'h0);
    check("C valP", valP, 64'h1);
    check("C pc_out", pc_out, 64'h0);
    tick();
    check("C halted", 64'(halted), 64'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("C hidden %0d", i), 64'(out_valid), 64'h0);
    end

    // ---- D: redirect in the same cycle as a response ----
    clear_mem();
    imem[0] = 8'h60; imem[1] = 8'h01;
    imem[256] = 8'h10; imem[257] = 8'h00;
    do_reset();
    rst_n = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    #1;
    check("D redirect mem_req", 64'(mem_req), 64'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("D out_valid after", 64'(out_valid), 64'h0);
    check("D mem_addr", mem_addr, 64'h100);
    check("D pc_out", pc_out, 64'h100);
    check("D mem_req", 64'(mem_req), 64'h1);
    rec("D0", 64'h100, 4'h1, 4'h0, 4'hF, 4'hF, 64'h101);
    accept();
    rec("D1", 64'h101, 4'h0, 4'h0, 4'hF, 4'hF, 64'h102);
    accept();
    check("D halted", 64'(halted), 64'h1);

    // ---- E: fault on second response, irmovq straddling it ----
    clear_mem();
    for (int i = 0; i < 6; i++) imem[i] = 8'h10;
    imem[6] = 8'h30; imem[7] = 8'hF1; imem[8] = 8'h11; imem[9] = 8'h22;
    imem[10] = 8'h33; imem[11] = 8'h44;
    do_reset();
    err_base = 64'd10;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rec($sformatf("E%0d", i), 64'(i), 4'h1, 4'h0, 4'hF, 4'hF, 64'(i + 1));
      tick();
    end
    wait_valid("E err");
    check("E imem_error", 64'(imem_error), 64'h1);
    check("E instr_valid", 64'(instr_valid), 64'h0);
    check("E pc_out", pc_out, 64'h6);
    tick();
    check("E halted", 64'(halted), 64'h1);
    check("E out_valid", 64'(out_valid), 64'h0);
    check("E mem_req", 64'(mem_req), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
